// File: rtl/note_scroller.sv
// Note scroller: buffers chart notes in a small FIFO, scrolls them toward slot 0
// (hit zone) one pixel column per divider step, judges player hits and keeps a
// saturating score. Optional build macro NOTE_SCROLLER_AUTOPLAY_EN replaces
// manual judging with an automatic hit at offset 3.
module note_scroller #(
  parameter int unsigned CLK_DIV    = 2500000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        note_valid,
  input  logic        note_blue,
  input  logic        note_rest,
  output logic        note_ready,
  input  logic        hit_red,
  input  logic        hit_blue,
  output logic [9:0]  red_notes,
  output logic [9:0]  blue_notes,
  output logic [2:0]  offset,
  output logic        step_pulse,
  output logic        hit_ok,
  output logic        miss,
  output logic [15:0] score
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DivW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [2:0]        offset_q, offset_d;
  logic [9:0]        red_q, red_d, blue_q, blue_d;
  logic [15:0]       score_q, score_d;
  logic              step_q, hit_q, hit_d, miss_q, miss_d;

  // FIFO entries are {rest, blue}
  logic [1:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  logic active, full, empty, step, shift, push, pop, good, new_r, new_b;

  assign active = (state_q == StRun);
  assign full   = (count_q == CntW'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign step   = active && (div_q == DivW'(CLK_DIV - 1));
  assign shift  = step && (offset_q == 3'd6);
  // Shift samples pre-push occupancy, so a push into an empty FIFO is not popped
  assign pop    = shift && !empty;
  assign push   = note_valid && !full;

  assign note_ready = !full;
  assign red_notes  = red_q;
  assign blue_notes = blue_q;
  assign offset     = offset_q;
  assign step_pulse = step_q;
  assign hit_ok     = hit_q;
  assign miss       = miss_q;
  assign score      = score_q;

  // Run/pause state machine next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run)  state_d = StRun;
      StRun:   if (!run) state_d = StPause;
      StPause: if (run)  state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // FIFO occupancy next state
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Divider, hit judging, scroll and shift datapath
  always_comb begin
    div_d    = div_q;
    offset_d = offset_q;
    red_d    = red_q;
    blue_d   = blue_q;
    score_d  = score_q;
    miss_d   = 1'b0;
    good     = 1'b0;
    new_r    = 1'b0;
    new_b    = 1'b0;
    if (active) begin
      div_d = step ? '0 : div_q + 1'b1;
`ifndef NOTE_SCROLLER_AUTOPLAY_EN
      // Judge on pre-shift slot 0; a cleared note then shifts out as empty
      if (hit_red || hit_blue) begin
        if (hit_red && !hit_blue && red_q[0]) begin
          red_d[0] = 1'b0;
          good     = 1'b1;
        end else if (hit_blue && !hit_red && blue_q[0]) begin
          blue_d[0] = 1'b0;
          good      = 1'b1;
        end else begin
          miss_d = 1'b1;
        end
      end
`else
      if (step && (offset_q == 3'd2) && (red_q[0] || blue_q[0])) begin
        red_d[0]  = 1'b0;
        blue_d[0] = 1'b0;
        good      = 1'b1;
      end
`endif
      if (step) begin
        if (offset_q == 3'd6) begin
          offset_d = 3'd0;
          if (red_d[0] || blue_d[0]) miss_d = 1'b1;
          if (!empty && !mem_q[rd_ptr_q][1]) begin
            new_r = !mem_q[rd_ptr_q][0];
            new_b = mem_q[rd_ptr_q][0];
          end
          red_d  = {new_r, red_d[9:1]};
          blue_d = {new_b, blue_d[9:1]};
        end else begin
          offset_d = offset_q + 3'd1;
        end
      end
    end
    hit_d = good;
    if (good && (score_q != 16'hFFFF)) score_d = score_q + 16'd1;
  end

`ifdef NOTE_SCROLLER_AUTOPLAY_EN
  logic unused_hits;
  assign unused_hits = hit_red ^ hit_blue;
`endif

  // State, pointer and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      offset_q <= 3'd0;
      red_q    <= '0;
      blue_q   <= '0;
      score_q  <= '0;
      step_q   <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      offset_q <= offset_d;
      red_q    <= red_d;
      blue_q   <= blue_d;
      score_q  <= score_d;
      step_q   <= step;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; emptied on reset through the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {note_rest, note_blue};
  end

endmodule

// File: doc/note_scroller.md
Name: note_scroller

Overview:
- Upstream feeder of the note-bitmap renderer: produces the 10-slot red/blue note vectors and the 3-bit sub-slot scroll offset that the renderer turns into 7-row bitmaps.
- Accepts a stream of chart notes through a valid/ready handshake and buffers them in a small FIFO.
- Scrolls the notes one pixel column at a time toward slot 0, the hit zone.
- Judges player hits at slot 0 and keeps a saturating score.

Parameters:
- CLK_DIV, 2500000: clock cycles per one-column scroll step (offset increment); minimum 2.
- FIFO_DEPTH, 4: number of pending chart entries buffered; power of two, 2..16.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = scroll, 0 = pause
- note_valid  in  1  chart entry offered
- note_blue  in  1  entry colour; 0 = red, 1 = blue; ignored when note_rest=1
- note_rest  in  1  entry is an empty gap slot
- note_ready  out  1  FIFO can accept an entry (= !full)
- hit_red  in  1  single-cycle, already-debounced red button pulse
- hit_blue  in  1  single-cycle, already-debounced blue button pulse
- red_notes  out  10  slot i holds a red note; slot 0 = hit zone
- blue_notes  out  10  slot i holds a blue note
- offset  out  3  sub-slot scroll position, 0..6
- step_pulse  out  1  one-cycle pulse on every offset change
- hit_ok  out  1  one-cycle pulse on a correct hit
- miss  out  1  one-cycle pulse on a wrong hit or an unhit note leaving slot 0
- score  out  16  count of correct hits, saturates at 16'hFFFF

Behaviour:
- Reset (synchronous; also when asserted mid-operation):
  - State = IDLE; FIFO emptied; divider = 0.
  - red_notes = 0, blue_notes = 0, offset = 0, score = 0.
  - step_pulse, hit_ok, miss = 0; note_ready = 1.
- FSM:
  - IDLE -> RUN when run=1.
  - RUN -> PAUSE when run=0.
  - PAUSE -> RUN when run=1.
  - In IDLE and PAUSE the divider, offset and notes hold; hit inputs are ignored; FIFO pushes are still accepted.
- Divider (RUN only): counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and generates a step, registered as step_pulse in the same cycle that offset and notes update.
- Step with offset < 6: offset = offset + 1.
- Step with offset == 6 (slot shift):
  - offset = 0.
  - red_notes = {new_r, red_notes[9:1]}; blue_notes = {new_b, blue_notes[9:1]}.
  - new_r/new_b come from popping the FIFO head: rest -> 0/0; red -> 1/0; blue -> 0/1.
  - If the FIFO is empty, new_r = new_b = 0 and nothing is popped.
  - If the outgoing slot 0 still holds a note, pulse miss.
- FIFO:
  - Push when note_valid && note_ready. Each entry stores {rest, blue}.
  - Push while empty in the same cycle as a shift: the shift sees empty, and the push is stored.
  - Push is blocked when full, even during a pop cycle; ready is a pure function of occupancy.
- Invariant: red_notes & blue_notes == 0 at all times.
- Hit judging (RUN only; evaluated on pre-shift slot 0):
  - hit_red && !hit_blue && red_notes[0]: clear red_notes[0], pulse hit_ok, score + 1 (saturating).
  - hit_blue && !hit_red && blue_notes[0]: clear blue_notes[0], pulse hit_ok, score + 1 (saturating).
  - Any other hit (wrong colour, empty slot, both buttons in the same cycle): pulse miss; notes unchanged.
- Hit in the same cycle as a shift: the hit is judged first. A correctly hit note is shifted out as empty, with no miss. Only one miss pulse is produced per cycle.
- All outputs are registered; a hit response appears one cycle after the button pulse.

Optional Feature:
- Macro: NOTE_SCROLLER_AUTOPLAY_EN.
- Defined:
  - hit_red and hit_blue are ignored.
  - In RUN, on each step that sets offset to 3, any note in slot 0 is cleared automatically with hit_ok and score + 1.
  - miss pulses only from FIFO-independent slot exits, which cannot occur for notes present at offset 3.
- Undefined: manual judging as above.

Test Plan:
- Reset: rst=1 then release, run=0 -> all note vectors 0, offset 0, score 0, note_ready 1; state stays IDLE for 50 cycles with no step_pulse.
- Scroll/shift (CLK_DIV=2): push red, rest, blue; run=1 -> offset sequence 0,1..6 then 0, one step per 2 cycles. After the first shift red_notes=10'h200; after the third shift blue_notes=10'h200 and red_notes=10'h080.
- FIFO full: FIFO_DEPTH=4, run=0, offer 5 entries -> note_ready drops after the 4th and the 5th is not accepted. After one shift in RUN, note_ready returns to 1.
- Correct hit: red note in slot 0, hit_red pulse -> next cycle red_notes[0]=0, hit_ok=1, score=1. Repeat with score preset to 16'hFFFF -> score stays at FFFF.
- Misses: hit_blue on a red slot 0 -> miss=1, note kept. hit_red+hit_blue together -> miss. An unhit red note shifted out -> miss pulse on the shift cycle.
- Pause/reset mid-run: run=0 at offset 4 -> offset and notes hold for 20 cycles and resume at 5. rst during RUN with 3 FIFO entries -> everything cleared next cycle.
